// File: rtl/timer_prescaler.sv
// Clock-enable generator for the 8-bit timer counter: power-of-two divider
// (2..128) or edge detector on a synchronised external clock pin.
module timer_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic [2:0]       i_cks,
    input  logic             i_ext_clk,
    input  logic             i_ext_edge,
    output logic             o_clk_ena,
    output logic [PRE_W-1:0] o_pre_cnt
);

    localparam logic [2:0] CKS_EXT = 3'd7;

    logic [PRE_W-1:0] r_pre_cnt;
    logic [2:0]       r_cks_q;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic             r_clk_ena;

    logic [3:0]       w_shamt;
    logic [PRE_W-1:0] w_mask;
    logic             w_tap_hit;
    logic             w_rise;
    logic             w_fall;
    logic             w_edge;

    // Low (k+1) bits all ones marks the last count of a 2^(k+1) period.
    assign w_shamt   = {1'b0, r_cks_q} + 4'd1;
    assign w_mask    = ~({PRE_W{1'b1}} << w_shamt);
    assign w_tap_hit = ((r_pre_cnt & w_mask) == w_mask);

    assign w_rise = r_sync2 & ~r_sync3;
    assign w_fall = ~r_sync2 & r_sync3;
    assign w_edge = i_ext_edge ? w_fall : w_rise;

    // The synchroniser shifts unconditionally so that mode or enable changes
    // never see stale history and fabricate an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pre_cnt <= '0;
            r_cks_q   <= 3'd0;
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync3   <= 1'b0;
            r_clk_ena <= 1'b0;
        end else begin
            r_sync1 <= i_ext_clk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (i_cks != r_cks_q) begin
                r_pre_cnt <= '0;
                r_clk_ena <= 1'b0;
                r_cks_q   <= i_cks;
            end else if (r_cks_q == CKS_EXT) begin
                r_clk_ena <= i_enable & w_edge;
            end else if (i_enable) begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
                r_clk_ena <= w_tap_hit;
            end else begin
                r_clk_ena <= 1'b0;
            end
        end
    end

    assign o_clk_ena = r_clk_ena;
    assign o_pre_cnt = r_pre_cnt;

endmodule

// File: tb/tb_timer_prescaler.sv
// Directed scoreboard bench for timer_prescaler: a cycle model predicts each
// output, plus fixed pulse-position checks for the divider and edge modes.
module tb_timer_prescaler;

    typedef struct packed {
        logic       ena;
        logic [7:0] pre;
    } expT;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [2:0] cks;
    logic       extClk;
    logic       extEdge;
    logic       clkEna;
    logic [7:0] preCnt;

    expT sbQ[$];
    int  checks = 0;
    int  errors = 0;

    int         mPre;
    logic [2:0] mSel;
    logic       mS1, mS2, mS3, mEna;

    logic       dutEna;
    logic [7:0] dutPre;

    timer_prescaler #(.PRE_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_enable   (enable),
        .i_cks      (cks),
        .i_ext_clk  (extClk),
        .i_ext_edge (extEdge),
        .o_clk_ena  (clkEna),
        .o_pre_cnt  (preCnt)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive inputs, advance the reference model one edge and queue its prediction.
    task automatic applyStimulus(input logic r, input logic e, input logic [2:0] c,
                                 input logic x, input logic g);
        logic edgeSeen;
        int   n;
        rst = r; enable = e; cks = c; extClk = x; extEdge = g;
        if (r) begin
            mPre = 0; mSel = 3'd0; mS1 = 0; mS2 = 0; mS3 = 0; mEna = 0;
        end else begin
            edgeSeen = g ? (!mS2 && mS3) : (mS2 && !mS3);
            if (c != mSel) begin
                mPre = 0; mEna = 0; mSel = c;
            end else if (mSel == 3'd7) begin
                mEna = e && edgeSeen;
            end else if (e) begin
                n    = 1 << (mSel + 1);
                mEna = ((mPre % n) == n - 1);
                mPre = (mPre + 1) % 256;
            end else begin
                mEna = 0;
            end
            mS3 = mS2; mS2 = mS1; mS1 = x;
        end
        sbQ.push_back('{ena: mEna, pre: 8'(mPre)});
    endtask

    task automatic checkOutput();
        expT e;
        dutEna = clkEna;
        dutPre = preCnt;
        if (sbQ.size() == 0) begin
            checkVal("sb_empty", 1, 0);
        end else begin
            e = sbQ.pop_front();
            checkVal("sb_clk_ena", dutEna, e.ena);
            checkVal("sb_pre_cnt", dutPre, e.pre);
        end
    endtask

    task automatic tick(input logic r, input logic e, input logic [2:0] c,
                        input logic x, input logic g);
        applyStimulus(r, e, c, x, g);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        int pulses;
        int firstAt;
        int secondAt;
        int lastAt;
        logic xv;

        rst = 1; enable = 1; cks = 0; extClk = 0; extEdge = 0;

        // Reset held 5 cycles, then divide-by-2 alternates starting at edge 2
        for (int i = 0; i < 5; i++) begin
            tick(1, 1, 3'd0, 0, 0);
            checkVal("rst_ena", dutEna, 0);
            checkVal("rst_pre", dutPre, 0);
        end
        for (int i = 1; i <= 6; i++) begin
            tick(0, 1, 3'd0, 0, 0);
            checkVal("div2_alt", dutEna, (i % 2 == 0) ? 1 : 0);
        end

        // Divide by 4: ten pulses in 40 edges, spaced 4 apart
        tick(0, 1, 3'd1, 0, 0);
        checkVal("div4_sel_ena", dutEna, 0);
        pulses = 0; lastAt = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(0, 1, 3'd1, 0, 0);
            if (dutEna) begin
                pulses++;
                checkVal("div4_spacing", i - lastAt, 4);
                lastAt = i;
            end
        end
        checkVal("div4_count", pulses, 10);

        // Divide by 128: pulses at edges 128 and 256, crossing the counter wrap
        tick(0, 1, 3'd6, 0, 0);
        firstAt = 0; secondAt = 0;
        for (int i = 1; i <= 256; i++) begin
            tick(0, 1, 3'd6, 0, 0);
            if (dutEna) begin
                if (firstAt == 0) firstAt = i;
                else if (secondAt == 0) secondAt = i;
            end
        end
        checkVal("div128_first", firstAt, 128);
        checkVal("div128_second", secondAt, 256);

        // Pause: enable low for 3 cycles after 5 enabled edges
        tick(1, 1, 3'd2, 0, 0);
        tick(0, 1, 3'd2, 0, 0);
        firstAt = 0;
        for (int i = 1; i <= 14; i++) begin
            tick(0, (i >= 6 && i <= 8) ? 1'b0 : 1'b1, 3'd2, 0, 0);
            if (i == 5) checkVal("pause_pre5", dutPre, 5);
            if (i >= 6 && i <= 8) begin
                checkVal("pause_hold", dutPre, 5);
                checkVal("pause_ena", dutEna, 0);
            end
            if (dutEna && firstAt == 0) firstAt = i;
        end
        checkVal("pause_first", firstAt, 11);

        // Select change mid-period from divide-by-16 to divide-by-2
        tick(0, 1, 3'd3, 0, 0);
        for (int i = 0; i < 9; i++) tick(0, 1, 3'd3, 0, 0);
        checkVal("sel_pre9", dutPre, 9);
        tick(0, 1, 3'd0, 0, 0);
        checkVal("sel_clr_pre", dutPre, 0);
        checkVal("sel_clr_ena", dutEna, 0);
        for (int i = 1; i <= 6; i++) begin
            tick(0, 1, 3'd0, 0, 0);
            checkVal("sel_div2", dutEna, (i % 2 == 0) ? 1 : 0);
        end

        // External rising edges, 8-cycle half period
        tick(0, 1, 3'd7, 0, 0);
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            xv = ((i / 8) % 2) == 1;
            tick(0, 1, 3'd7, xv, 0);
            if (dutEna) begin
                pulses++;
                checkVal("ext_rise_pos", i % 16, 10);
            end
        end
        checkVal("ext_rise_cnt", pulses, 4);
        checkVal("ext_hold_pre", dutPre, 0);

        // External falling edges
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            xv = ((i / 8) % 2) == 1;
            tick(0, 1, 3'd7, xv, 1);
            if (dutEna) begin
                pulses++;
                checkVal("ext_fall_pos", i % 16, 2);
            end
        end
        checkVal("ext_fall_cnt", pulses, 4);

        // External with enable off: a rise while disabled must not surface later
        pulses = 0;
        for (int i = 0; i < 4; i++) tick(0, 0, 3'd7, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 3'd7, 1, 0);
            if (dutEna) pulses++;
        end
        for (int i = 0; i < 6; i++) begin
            tick(0, 1, 3'd7, 1, 0);
            if (dutEna) pulses++;
        end
        checkVal("ext_en_off_none", pulses, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 3'd7, 0, 0);
        pulses = 0; firstAt = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(0, 1, 3'd7, 1, 0);
            if (dutEna) begin
                pulses++;
                if (firstAt == 0) firstAt = i;
            end
        end
        checkVal("ext_real_rise_at", firstAt, 3);
        checkVal("ext_real_rise_cnt", pulses, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
